// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM request server.
package vram_pkg;

    localparam int unsigned ADDR_W_DEF      = 16;
    localparam int unsigned DATA_W_DEF      = 16;
    localparam int unsigned WFIFO_DEPTH_DEF = 4;
    localparam int unsigned RFIFO_DEPTH_DEF = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDW
    } arb_state_t;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with count-derived flags; a push while full is discarded.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           din_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + 1'b1;
            end else if (do_pop && !do_push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vram_req_server.sv
// VRAM request server: queues client writes/reads and arbitrates them onto one RAM port.
// Define VRAM_RAW_ORDER_EN to hold reads back until all earlier writes are committed.
module vram_req_server
    import vram_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned WFIFO_DEPTH = WFIFO_DEPTH_DEF,
    parameter int unsigned RFIFO_DEPTH = RFIFO_DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              write,
    input  logic [ADDR_W-1:0] writeaddr,
    input  logic [DATA_W-1:0] writedata,
    output logic              wr_full,
    output logic              wr_drop,
    input  logic              read,
    input  logic [ADDR_W-1:0] readaddr,
    output logic              rd_full,
    output logic [DATA_W-1:0] readdata,
    output logic              rd_empty,
    input  logic              rd_pop,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int unsigned WrW   = ADDR_W + DATA_W;
    localparam int unsigned WCntW = $clog2(WFIFO_DEPTH + 1);
    localparam int unsigned RCntW = $clog2(RFIFO_DEPTH + 1);

    arb_state_t        state_q;
    logic              last_rd_q;
    logic              wr_drop_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [WrW-1:0]    wf_head;
    logic              wf_empty;
    logic [ADDR_W-1:0] ra_head;
    logic              ra_empty;
    logic [DATA_W-1:0] rd_head;
    logic              rdq_full;
    logic [WCntW-1:0]  wf_count_unused;
    logic [RCntW-1:0]  ra_count_unused;
    logic [RCntW-1:0]  rd_count_unused;
    logic              wr_pend, rd_elig;

    sync_fifo #(.WIDTH(WrW), .DEPTH(WFIFO_DEPTH)) u_wr_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (write),
        .pop_i   (state_q == S_WR),
        .din_i   ({writeaddr, writedata}),
        .dout_o  (wf_head),
        .full_o  (wr_full),
        .empty_o (wf_empty),
        .count_o (wf_count_unused)
    );

    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(RFIFO_DEPTH)) u_ra_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (read),
        .pop_i   (state_q == S_RD),
        .din_i   (readaddr),
        .dout_o  (ra_head),
        .full_o  (rd_full),
        .empty_o (ra_empty),
        .count_o (ra_count_unused)
    );

    sync_fifo #(.WIDTH(DATA_W), .DEPTH(RFIFO_DEPTH)) u_rd_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (state_q == S_RDW),
        .pop_i   (rd_pop),
        .din_i   (mem_rdata),
        .dout_o  (rd_head),
        .full_o  (rdq_full),
        .empty_o (rd_empty),
        .count_o (rd_count_unused)
    );

    assign wr_pend = !wf_empty;
`ifdef VRAM_RAW_ORDER_EN
    assign rd_elig = !ra_empty && !rdq_full && wf_empty;
`else
    assign rd_elig = !ra_empty && !rdq_full;
`endif

    assign wr_drop   = wr_drop_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign readdata  = rd_empty ? '0 : rd_head;

    // last_rd_q resets high so the first contested slot goes to the write.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_rd_q   <= 1'b1;
            wr_drop_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            wr_drop_q <= write && wr_full;
            unique case (state_q)
                S_IDLE: begin
                    if (wr_pend && (!rd_elig || last_rd_q)) begin
                        state_q     <= S_WR;
                        last_rd_q   <= 1'b0;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= wf_head[WrW-1:DATA_W];
                        mem_wdata_q <= wf_head[DATA_W-1:0];
                    end else if (rd_elig) begin
                        state_q    <= S_RD;
                        last_rd_q  <= 1'b1;
                        mem_addr_q <= ra_head;
                    end
                end
                S_WR: begin
                    state_q  <= S_IDLE;
                    mem_we_q <= 1'b0;
                end
                S_RD:    state_q <= S_RDW;
                S_RDW:   state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vram_req_server.sv
// Self-checking bench for vram_req_server: directed vector table, corner sequences, random run.
module tb_vram_req_server;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        write = 1'b0, read = 1'b0, rd_pop = 1'b0;
    logic [15:0] writeaddr = '0, writedata = '0, readaddr = '0;
    logic        wr_full, wr_drop, rd_full, rd_empty, mem_we;
    logic [15:0] readdata, mem_addr, mem_wdata;
    logic [15:0] mem_rdata = '0;

    logic [15:0] ram [0:65535];
    logic        poke_en = 1'b0;
    logic [15:0] poke_addr = '0, poke_data = '0;
    int          we_cnt = 0;
    int          n_tests = 0, n_fail = 0;

    always #5 clk = ~clk;

    vram_req_server dut (
        .clk       (clk),
        .reset     (reset),
        .write     (write),
        .writeaddr (writeaddr),
        .writedata (writedata),
        .wr_full   (wr_full),
        .wr_drop   (wr_drop),
        .read      (read),
        .readaddr  (readaddr),
        .rd_full   (rd_full),
        .readdata  (readdata),
        .rd_empty  (rd_empty),
        .rd_pop    (rd_pop),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous RAM with one-cycle read latency; the bench can poke it directly.
    always @(posedge clk) begin
        if (poke_en) ram[poke_addr] <= poke_data;
        else if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
        if (mem_we) we_cnt <= we_cnt + 1;
    end

    function automatic logic [15:0] pre(input logic [15:0] a);
        return {a[7:0], ~a[7:0]};
    endfunction

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: DUT output with no matching expected entry", name);
    endtask

    task automatic do_reset();
        reset = 1'b1; write = 1'b0; read = 1'b0; rd_pop = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle_inputs();
        write = 1'b0; read = 1'b0; rd_pop = 1'b0;
    endtask

    typedef struct {
        logic w; logic [15:0] wa; logic [15:0] wd;
        logic r; logic [15:0] ra; logic pop;
        logic we; logic [15:0] ma; logic [15:0] mwd; logic empty; logic [15:0] rdat;
    } vec_t;

    function automatic vec_t mk(input logic w, input logic [15:0] wa, input logic [15:0] wd,
                                input logic r, input logic [15:0] ra, input logic pop,
                                input logic we, input logic [15:0] ma, input logic [15:0] mwd,
                                input logic empty, input logic [15:0] rdat);
        vec_t v;
        v.w = w; v.wa = wa; v.wd = wd; v.r = r; v.ra = ra; v.pop = pop;
        v.we = we; v.ma = ma; v.mwd = mwd; v.empty = empty; v.rdat = rdat;
        return v;
    endfunction

    vec_t        tbl [14];
    logic [31:0] wq [$];
    logic [15:0] rq [$];

    initial begin
        logic        seen_full, drop_exp, w, r, p, active;
        logic [15:0] wa, wd, ra;
        int          accepted, we0, n;

        // Entry i: inputs applied before edge i, outputs expected in the cycle after it.
        tbl[0]  = mk(1'b1, 16'h0003, 16'h0003, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0);
        tbl[1]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[2]  = mk(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[3]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[4]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[5]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b0, 16'h0003);
        tbl[6]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[7]  = mk(1'b1, 16'h0003, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'h0003, 1'b1, 16'h0);
        tbl[8]  = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0003, 16'hBEEF, 1'b1, 16'h0);
        tbl[9]  = mk(1'b0, 16'h0, 16'h0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0003, 16'hBEEF, 1'b1, 16'h0);
        tbl[10] = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'hBEEF, 1'b1, 16'h0);
        tbl[11] = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'hBEEF, 1'b1, 16'h0);
        tbl[12] = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0003, 16'hBEEF, 1'b0, 16'hBEEF);
        tbl[13] = mk(1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0003, 16'hBEEF, 1'b1, 16'h0);

        @(negedge clk);
        do_reset();
        chk1("rst_wr_full", wr_full, 1'b0);
        chk1("rst_rd_full", rd_full, 1'b0);
        chk1("rst_rd_empty", rd_empty, 1'b1);
        chk16("rst_readdata", readdata, 16'h0);
        chk1("rst_wr_drop", wr_drop, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0);
        chk16("rst_mem_wdata", mem_wdata, 16'h0);

        // Write then read-back vectors.
        for (int i = 0; i < 14; i++) begin
            write = tbl[i].w; writeaddr = tbl[i].wa; writedata = tbl[i].wd;
            read = tbl[i].r; readaddr = tbl[i].ra; rd_pop = tbl[i].pop;
            @(negedge clk);
            chk1($sformatf("vec%0d_mem_we", i), mem_we, tbl[i].we);
            chk16($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].ma);
            chk16($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].mwd);
            chk1($sformatf("vec%0d_rd_empty", i), rd_empty, tbl[i].empty);
            chk16($sformatf("vec%0d_readdata", i), readdata, tbl[i].rdat);
            chk1($sformatf("vec%0d_wr_full", i), wr_full, 1'b0);
            chk1($sformatf("vec%0d_wr_drop", i), wr_drop, 1'b0);
        end
        idle_inputs();

        // Write and read pending together: W first, then alternation.
        do_reset();
        for (int c = 0; c < 8; c++) begin
            write = (c < 2); read = (c < 2);
            writeaddr = 16'h0020 + 16'(c); writedata = (c == 0) ? 16'h1111 : 16'h2222;
            readaddr = 16'h0020 + 16'(c);
            @(negedge clk);
`ifndef VRAM_RAW_ORDER_EN
            chk1($sformatf("alt_we_c%0d", c), mem_we, (c == 1) || (c == 6));
`endif
        end
        idle_inputs();
        for (int k = 0; k < 2; k++) begin
            n = 0;
            while (rd_empty && n < 30) begin @(negedge clk); n++; end
            chk1("alt_rd_avail", rd_empty, 1'b0);
            chk16($sformatf("alt_rd%0d", k), readdata, (k == 0) ? 16'h1111 : 16'h2222);
            rd_pop = 1'b1; @(negedge clk); rd_pop = 1'b0;
        end

        // Preload a read-only region for later reads.
        do_reset();
        for (int a = 0; a < 16; a++) begin
            n = 0;
            while (wr_full && n < 20) begin @(negedge clk); n++; end
            write = 1'b1; writeaddr = 16'h0040 + 16'(a); writedata = pre(16'h0040 + 16'(a));
            @(negedge clk);
        end
        idle_inputs();
        repeat (20) @(negedge clk);
        chk16("preload_last", ram[16'h004F], pre(16'h004F));

        // Five reads without popping: the fifth must wait for space in the data FIFO.
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (rd_full && n < 20) begin @(negedge clk); n++; end
            chk1("t5_rd_accept", rd_full, 1'b0);
            read = 1'b1; readaddr = 16'h0040 + 16'(k);
            @(negedge clk);
        end
        idle_inputs();
        repeat (40) @(negedge clk);
        chk1("t5_queued", rd_empty, 1'b0);
        poke_en = 1'b1; poke_addr = 16'h0044; poke_data = 16'hC0DE;
        @(negedge clk);
        poke_en = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            while (rd_empty && n < 20) begin @(negedge clk); n++; end
            chk16($sformatf("t5_rd%0d", k), readdata,
                  (k == 4) ? 16'hC0DE : pre(16'h0040 + 16'(k)));
            rd_pop = 1'b1; @(negedge clk); rd_pop = 1'b0;
        end
        repeat (5) @(negedge clk);
        chk1("t5_drained", rd_empty, 1'b1);
        poke_en = 1'b1; poke_addr = 16'h0044; poke_data = pre(16'h0044);
        @(negedge clk);
        poke_en = 1'b0;

        // Back-to-back writes until full, then one dropped write.
        do_reset();
        accepted = 0; we0 = we_cnt; seen_full = 1'b0;
        for (int i = 0; i < 40 && !seen_full; i++) begin
            if (wr_full) begin
                seen_full = 1'b1;
            end else begin
                write = 1'b1; writeaddr = 16'h0200 + 16'(i); writedata = 16'h1000 + 16'(i);
                accepted++;
                @(negedge clk);
            end
        end
        chk1("t3_full_seen", seen_full, 1'b1);
        write = 1'b1; writeaddr = 16'h02FF; writedata = 16'hDEAD;
        @(negedge clk);
        write = 1'b0;
        chk1("t3_drop_pulse", wr_drop, 1'b1);
        @(negedge clk);
        chk1("t3_drop_end", wr_drop, 1'b0);
        repeat (30) @(negedge clk);
        chk16("t3_mem_writes", 16'(we_cnt - we0), 16'(accepted));
        chk16("t3_dropped_not_written", ram[16'h02FF], 16'h0000);
        chk16("t3_last_written", ram[16'h0200 + 16'(accepted - 1)], 16'h1000 + 16'(accepted - 1));

        // Reset while a read is in its data-capture cycle, with a write queued behind it.
        do_reset();
        read = 1'b1; readaddr = 16'h0041;
        @(negedge clk);
        read = 1'b0;
        @(negedge clk);
        write = 1'b1; writeaddr = 16'h0300; writedata = 16'hDEAD;
        @(negedge clk);
        write = 1'b0;
        we0 = we_cnt;
        reset = 1'b1;
        @(negedge clk);
        chk1("t6_rd_empty", rd_empty, 1'b1);
        chk1("t6_mem_we", mem_we, 1'b0);
        chk1("t6_wr_full", wr_full, 1'b0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk1("t6_still_empty", rd_empty, 1'b1);
        chk16("t6_no_commit", 16'(we_cnt - we0), 16'h0000);
        chk16("t6_ram_untouched", ram[16'h0300], 16'h0000);

        // Random traffic against a queue model: writes to 0x01xx, reads from the preload region.
        do_reset();
        drop_exp = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            chk1("rand_wr_full", wr_full, wq.size() == 4);
            chk1("rand_wr_drop", wr_drop, drop_exp);
            if (mem_we) begin
                if (wq.size() == 0) fail_now("rand_unexpected_write");
                else begin
                    chk16("rand_mem_addr", mem_addr, wq[0][31:16]);
                    chk16("rand_mem_wdata", mem_wdata, wq[0][15:0]);
                    void'(wq.pop_front());
                end
            end
            if (rd_empty) chk16("rand_rd_zero", readdata, 16'h0000);
            else if (rq.size() == 0) fail_now("rand_unexpected_read");
            else chk16("rand_readdata", readdata, rq[0]);

            active = (cyc < 500);
            w = active && ($urandom_range(1) == 1);
            r = active && ($urandom_range(2) == 0);
            p = !active || ($urandom_range(3) != 0);
            wa = 16'h0100 | 16'($urandom_range(255));
            wd = 16'($urandom);
            ra = 16'h0040 | 16'($urandom_range(15));
            write = w; writeaddr = wa; writedata = wd;
            read = r; readaddr = ra; rd_pop = p;
            drop_exp = w && wr_full;
            if (w && !wr_full) wq.push_back({wa, wd});
            if (r && !rd_full) rq.push_back(pre(ra));
            if (p && !rd_empty && rq.size() != 0) void'(rq.pop_front());
            @(negedge clk);
        end
        idle_inputs();
        chk16("rand_writes_drained", 16'(wq.size()), 16'h0000);
        chk16("rand_reads_drained", 16'(rq.size()), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
